// File: rtl/sync_fifo_gen2_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode encoding,
// depth / level-width derivation and threshold legality limits.
package sync_fifo_gen2_pkg;

    // Read-port behaviour selected by the FWFT parameter of the top level
    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    // Lowest legal almost-full threshold (upper bound is the depth)
    localparam int AFULL_TH_MIN  = 1;
    // Lowest legal almost-empty threshold (upper bound is depth - 1)
    localparam int AEMPTY_TH_MIN = 0;

    // Number of storage words for a given address width
    function automatic int fifoDepth(input int addrWidth);
        return 1 << addrWidth;
    endfunction

    // LEVEL and pointers carry one extra bit so that 0..DEPTH is representable
    function automatic int fifoLevelWidth(input int addrWidth);
        return addrWidth + 1;
    endfunction

    // True when both flag thresholds fall inside their meaningful ranges
    function automatic bit thresholdsLegal(input int addrWidth,
                                           input int afullTh,
                                           input int aemptyTh);
        int depth;
        depth = fifoDepth(addrWidth);
        return (afullTh >= AFULL_TH_MIN) && (afullTh <= depth) &&
               (aemptyTh >= AEMPTY_TH_MIN) && (aemptyTh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_reg_array.sv
// DEPTH x DATA_WIDTH register array with one write port and one
// combinational read port. Contents are deliberately not reset.
module fifo_reg_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word whenever the controller accepts a write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO controller: pointers, registered level and flags,
// sticky error flags, flush, and the std-mode registered read stage.
module sync_fifo_gen2
    import sync_fifo_gen2_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  W_INC,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int         DEPTH = fifoDepth(ADDR_WIDTH);
    localparam int         LW    = fifoLevelWidth(ADDR_WIDTH);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;

    localparam logic [LW-1:0] PTR_ONE    = LW'(1);
    localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AFULL  = LW'(AFULL_TH);
    localparam logic [LW-1:0] LVL_AEMPTY = LW'(AEMPTY_TH);

    if (!thresholdsLegal(ADDR_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_badThreshold
        $error("sync_fifo_gen2: AFULL_TH or AEMPTY_TH outside legal range");
    end

    logic [LW-1:0]         wrPtr_q, wrPtr_d;
    logic [LW-1:0]         rdPtr_q, rdPtr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rdValid_q, rdValid_d;
    logic [DATA_WIDTH-1:0] rdData_q, rdData_d;

    logic                  wrOk;
    logic                  rdOk;
    logic                  memWe;
    logic [DATA_WIDTH-1:0] memRdData;

    fifo_reg_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_regArray (
        .clk_i   (CLK),
        .we_i    (memWe),
        .waddr_i (wrPtr_q[ADDR_WIDTH-1:0]),
        .wdata_i (WR_DATA),
        .raddr_i (rdPtr_q[ADDR_WIDTH-1:0]),
        .rdata_o (memRdData)
    );

    // Decide which requests are accepted and derive every next-state value
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        rdValid_d = 1'b0;
        rdData_d  = rdData_q;
        memWe     = 1'b0;

        // A read never bypasses: an empty FIFO rejects it even with a write
        rdOk = R_INC & ~empty_q;
        // Full accepts a write only when a read frees a slot on the same edge
        wrOk = W_INC & (~full_q | rdOk);

        if (FLUSH) begin
            rdPtr_d = wrPtr_q;
            level_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wrOk) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
                memWe   = 1'b1;
            end
            if (rdOk) begin
                rdPtr_d  = rdPtr_q + PTR_ONE;
                rdData_d = memRdData;
            end
            rdValid_d = rdOk;
            level_d   = wrPtr_d - rdPtr_d;
            ovf_d     = ovf_q | (W_INC & ~wrOk);
            unf_d     = unf_q | (R_INC & empty_q);
        end

        full_d   = (level_d == LVL_FULL);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= LVL_AFULL);
        aempty_d = (level_d <= LVL_AEMPTY);
    end

    // Register pointers, level, flags and the read stage; reset wins over flush
    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rdValid_q <= rdValid_d;
            rdData_q  <= rdData_d;
        end
    end

    // FWFT shows the head word directly; std mode presents the registered pop
    if (MODE == FIFO_MODE_FWFT) begin : g_fwftRead
        assign RD_DATA  = memRdData;
        assign RD_VALID = ~empty_q;
    end else begin : g_stdRead
        assign RD_DATA  = rdData_q;
        assign RD_VALID = rdValid_q;
    end

    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign LEVEL        = level_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule
